// File: rtl/reu_dma_seq.sv
// REU DMA sequencer: drives C64 DMA/bus cycle controls, SDRAM strobes and
// register-file strobes; one byte per PHI2 cycle, two for swap.
// Ports: PHI2 (state on falling edge), Reset (sync, active-high),
//   Execute/XferType/Length1 from the register file, BA, RAMReady, Match;
//   DMA, AddrOE, C64RW, DataOE, C64Latch, RAMRD, RAMWR to bus and SDRAM;
//   IncCA, IncREUA, DecLen, XferEnd, SetEndBlock, SetFault back to the
//   register file; Busy.
// Option: define REU_BA_STALL_EN to make BA low stall the bus cycles.
module reu_dma_seq #(
   parameter int START_WAIT = 1
) (
   input  logic       PHI2,
   input  logic       Reset,
   input  logic       Execute,
   input  logic [1:0] XferType,
   input  logic       Length1,
   input  logic       BA,
   input  logic       RAMReady,
   input  logic       Match,
   output logic       DMA,
   output logic       AddrOE,
   output logic       C64RW,
   output logic       DataOE,
   output logic       C64Latch,
   output logic       RAMRD,
   output logic       RAMWR,
   output logic       IncCA,
   output logic       IncREUA,
   output logic       DecLen,
   output logic       XferEnd,
   output logic       SetEndBlock,
   output logic       SetFault,
   output logic       Busy
);

   typedef enum logic [1:0] {
      S_IDLE, S_START, S_XA, S_XB
   } state_t;

   localparam logic [1:0] XT_STASH  = 2'b00;
   localparam logic [1:0] XT_FETCH  = 2'b01;
   localparam logic [1:0] XT_SWAP   = 2'b10;
   localparam logic [1:0] XT_VERIFY = 2'b11;
   localparam logic [1:0] WAIT_LAST = 2'(START_WAIT - 1);

   state_t     state_q, state_d;
   logic [1:0] xt_q, xt_d;
   logic [1:0] wait_q, wait_d;
   logic       wrpend_q, wrpend_d;

   logic stall;
   logic in_xa, in_xb;
   logic done;
   logic fault;

`ifdef REU_BA_STALL_EN
   assign stall = !BA || !RAMReady;
`else
   // BA is ignored: board glue already keeps DMA off VIC cycles.
   logic ba_ign;
   assign ba_ign = BA & 1'b0;
   assign stall  = !RAMReady || ba_ign;
`endif

   assign in_xa = (state_q == S_XA) && !stall;
   assign in_xb = (state_q == S_XB) && !stall;
   assign done  = (in_xa && (xt_q != XT_SWAP)) || in_xb;
   assign fault = in_xa && (xt_q == XT_VERIFY) && !Match;

   always_ff @(negedge PHI2) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         xt_q     <= 2'b00;
         wait_q   <= 2'b00;
         wrpend_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         xt_q     <= xt_d;
         wait_q   <= wait_d;
         wrpend_q <= wrpend_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      xt_d     = xt_q;
      wait_d   = wait_q;
      // A stashed byte is written to SDRAM during the following cycle.
      wrpend_d = in_xa && (xt_q == XT_STASH);
      unique case (state_q)
         S_IDLE: begin
            if (Execute) begin
               xt_d    = XferType;
               wait_d  = 2'b00;
               state_d = S_START;
            end
         end
         S_START: begin
            if (wait_q == WAIT_LAST) state_d = S_XA;
            else wait_d = wait_q + 2'd1;
         end
         S_XA: begin
            if (!stall) begin
               if (xt_q == XT_SWAP) state_d = S_XB;
               else if (Length1 || fault) state_d = S_IDLE;
            end
         end
         S_XB: begin
            if (!stall) state_d = Length1 ? S_IDLE : S_XA;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      DMA         = (state_q != S_IDLE);
      Busy        = (state_q != S_IDLE);
      AddrOE      = 1'b0;
      C64RW       = 1'b1;
      DataOE      = 1'b0;
      C64Latch    = 1'b0;
      RAMRD       = 1'b0;
      RAMWR       = wrpend_q;
      IncCA       = 1'b0;
      IncREUA     = 1'b0;
      DecLen      = 1'b0;
      XferEnd     = 1'b0;
      SetEndBlock = 1'b0;
      SetFault    = 1'b0;
      if (in_xa) begin
         AddrOE = 1'b1;
         unique case (xt_q)
            XT_STASH: C64Latch = 1'b1;
            XT_FETCH: begin
               RAMRD  = 1'b1;
               C64RW  = 1'b0;
               DataOE = 1'b1;
            end
            XT_SWAP: begin
               C64Latch = 1'b1;
               RAMRD    = 1'b1;
            end
            XT_VERIFY: RAMRD = 1'b1;
            default: ;
         endcase
      end
      if (in_xb) begin
         AddrOE = 1'b1;
         C64RW  = 1'b0;
         DataOE = 1'b1;
         RAMWR  = 1'b1;
      end
      // A reset cycle aborts: no register-file updates leak out.
      if (done && !Reset) begin
         IncCA       = 1'b1;
         IncREUA     = 1'b1;
         DecLen      = !Length1;
         XferEnd     = Length1 || fault;
         SetEndBlock = Length1;
         SetFault    = fault;
      end
   end

endmodule

// File: tb/tb_reu_dma_seq.sv
// Directed bench for reu_dma_seq with a small register-file model
// (length and CA counters) driven by the sequencer strobes.
module tb_reu_dma_seq;

   logic       PHI2;
   logic       Reset;
   logic       Execute;
   logic [1:0] XferType;
   logic       Length1;
   logic       BA;
   logic       RAMReady;
   logic       Match;
   logic DMA, AddrOE, C64RW, DataOE, C64Latch, RAMRD, RAMWR;
   logic IncCA, IncREUA, DecLen, XferEnd, SetEndBlock, SetFault, Busy;

   int tests = 0;
   int fails = 0;

   logic        ld;
   logic [16:0] ld_val;
   logic [16:0] len;
   int          ca;

   // Order: DMA Busy | AddrOE C64RW DataOE | C64Latch RAMRD RAMWR |
   //        IncCA IncREUA DecLen | XferEnd SetEndBlock SetFault
   logic [13:0] obs;
   assign obs = {DMA, Busy, AddrOE, C64RW, DataOE, C64Latch, RAMRD,
                 RAMWR, IncCA, IncREUA, DecLen, XferEnd, SetEndBlock,
                 SetFault};

   localparam logic [13:0] O_IDLE = 14'b00_010_000_000_000;
   localparam logic [13:0] O_IDWR = 14'b00_010_001_000_000;
   localparam logic [13:0] O_STRT = 14'b11_010_000_000_000;

   reu_dma_seq dut (
      .PHI2(PHI2), .Reset(Reset), .Execute(Execute),
      .XferType(XferType), .Length1(Length1), .BA(BA),
      .RAMReady(RAMReady), .Match(Match), .DMA(DMA),
      .AddrOE(AddrOE), .C64RW(C64RW), .DataOE(DataOE),
      .C64Latch(C64Latch), .RAMRD(RAMRD), .RAMWR(RAMWR),
      .IncCA(IncCA), .IncREUA(IncREUA), .DecLen(DecLen),
      .XferEnd(XferEnd), .SetEndBlock(SetEndBlock),
      .SetFault(SetFault), .Busy(Busy)
   );

   initial begin
      PHI2 = 1'b1;
      forever #5 PHI2 = ~PHI2;
   end

   always @(negedge PHI2) begin
      if (ld) begin
         len <= ld_val;
         ca  <= 0;
      end else begin
         if (DecLen) len <= len - 17'd1;
         if (IncCA) ca <= ca + 1;
      end
   end
   assign Length1 = (len == 17'd1);

   task automatic step(input string tag, input logic [13:0] exp);
      #2;
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %b want %b", tag, obs, exp);
      end
      @(negedge PHI2);
      #1;
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic start(input logic [1:0] xt, input int n);
      Execute  = 1'b1;
      XferType = xt;
      ld       = 1'b1;
      ld_val   = 17'(n);
      step("exec_idle", O_IDLE);
      Execute  = 1'b0;
      ld       = 1'b0;
   endtask

   initial begin
      Reset    = 1'b1;
      Execute  = 1'b0;
      XferType = 2'b00;
      BA       = 1'b1;
      RAMReady = 1'b1;
      Match    = 1'b1;
      ld       = 1'b1;
      ld_val   = 17'd0;
      @(negedge PHI2);
      #1;
      step("reset", O_IDLE);
      Reset = 1'b0;
      ld    = 1'b0;
      step("idle", O_IDLE);

      // Stash, length 3
      start(2'b00, 3);
      step("st_start", O_STRT);
      step("st_b1", 14'b11_110_100_111_000);
      step("st_b2", 14'b11_110_101_111_000);
      step("st_b3", 14'b11_110_101_110_110);
      step("st_wr", O_IDWR);
      step("st_idle", O_IDLE);
      chk("st_ca", ca, 3);

      // Fetch, length 1; Execute on the last byte is ignored
      start(2'b01, 1);
      step("fe_start", O_STRT);
      Execute = 1'b1;
      step("fe_b1", 14'b11_101_010_110_110);
      Execute = 1'b0;
      step("fe_end", O_IDLE);
      step("fe_idle", O_IDLE);

      // Swap, length 2
      start(2'b10, 2);
      step("sw_start", O_STRT);
      step("sw_xa1", 14'b11_110_110_000_000);
      step("sw_xb1", 14'b11_101_001_111_000);
      step("sw_xa2", 14'b11_110_110_000_000);
      step("sw_xb2", 14'b11_101_001_110_110);
      step("sw_idle", O_IDLE);
      chk("sw_ca", ca, 2);

      // Verify, length 4, mismatch on byte 2
      start(2'b11, 4);
      step("vf_start", O_STRT);
      step("vf_b1", 14'b11_110_010_111_000);
      Match = 1'b0;
      step("vf_b2", 14'b11_110_010_111_101);
      Match = 1'b1;
      step("vf_idle", O_IDLE);
      step("vf_idle2", O_IDLE);
      chk("vf_ca", ca, 2);
      chk("vf_len", int'(len), 2);

      // RAMReady stall during fetch; Execute while busy ignored
      start(2'b01, 2);
      Execute  = 1'b1;
      XferType = 2'b00;
      step("rr_start", O_STRT);
      Execute  = 1'b0;
      RAMReady = 1'b0;
      step("rr_stall1", O_STRT);
      step("rr_stall2", O_STRT);
      chk("rr_ca", ca, 0);
      RAMReady = 1'b1;
      step("rr_b1", 14'b11_101_010_111_000);
      step("rr_b2", 14'b11_101_010_110_110);
      step("rr_idle", O_IDLE);

      // BA low for 3 cycles mid-stash
      start(2'b00, 3);
      step("ba_start", O_STRT);
      step("ba_b1", 14'b11_110_100_111_000);
      BA = 1'b0;
`ifdef REU_BA_STALL_EN
      step("ba_stall1", 14'b11_010_001_000_000);
      step("ba_stall2", O_STRT);
      step("ba_stall3", O_STRT);
      chk("ba_ca", ca, 1);
      BA = 1'b1;
      step("ba_b2", 14'b11_110_100_111_000);
      step("ba_b3", 14'b11_110_101_110_110);
`else
      step("ba_b2", 14'b11_110_101_111_000);
      step("ba_b3", 14'b11_110_101_110_110);
`endif
      step("ba_wr", O_IDWR);
      BA = 1'b1;
      step("ba_idle", O_IDLE);
      chk("ba_ca_end", ca, 3);

      // Reset asserted in XB of a swap
      start(2'b10, 2);
      step("rs_start", O_STRT);
      step("rs_xa", 14'b11_110_110_000_000);
      Reset = 1'b1;
      #2;
      tests++;
      assert ({DMA, XferEnd} === 2'b10) else begin
         fails++;
         $error("FAIL rs_xb: got %b want 10", {DMA, XferEnd});
      end
      @(negedge PHI2);
      #1;
      Reset = 1'b0;
      step("rs_idle", O_IDLE);
      step("rs_idle2", O_IDLE);

      // Clean restart: verify, length 1, matching
      start(2'b11, 1);
      step("rv_start", O_STRT);
      step("rv_b1", 14'b11_110_010_110_110);
      step("rv_idle", O_IDLE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
